// File: rtl/control_unit.sv
// -----------------------------------------------------------------------------
// control_unit
//
// Hardwired control sequencer for the CPU datapath. It runs the three fetch
// steps (T0-T2), decodes the opcode in ir[31:27] and then sequences the
// execute steps (T3-T7) of that instruction. Every datapath control strobe
// is a combinational function of the current step, the IR and the CON
// flip-flop, so the datapath needs no sequencing of its own.
//
// Parameters:
//   MEM_WAIT  extra cycles that read+MDRin are held on memory-read steps
//             (0 = single-cycle RAM)
//
// Ports:
//   clk        system clock, all state on the rising edge
//   clr        asynchronous active-low reset
//   ir         IR contents, opcode = ir[31:27]
//   con_ff     branch condition from the CON flip-flop
//   stop       pause request, sampled at the end of each instruction
//   in_strobe  external input-port load request (passed to InPortIn)
//   read .. PCout  datapath control strobes
//   opcode     ALU operation
//   run        1 while executing, 0 in PAUSE/HALT/reset
//   step       current step number (8 = PAUSE, 9 = HALT), debug only
// -----------------------------------------------------------------------------
module control_unit #(
    parameter int MEM_WAIT = 0
) (
    input  logic        clk,
    input  logic        clr,
    input  logic [31:0] ir,
    input  logic        con_ff,
    input  logic        stop,
    input  logic        in_strobe,
    output logic        read,
    output logic        write,
    output logic        BAout,
    output logic        Rin,
    output logic        Rout,
    output logic        Gra,
    output logic        Grb,
    output logic        Grc,
    output logic        CONN_in,
    output logic        MARin,
    output logic        MDRin,
    output logic        HIin,
    output logic        LOin,
    output logic        Yin,
    output logic        Zin,
    output logic        PCin,
    output logic        IRin,
    output logic        incPC,
    output logic        InPortIn,
    output logic        OutPortIn,
    output logic        HIout,
    output logic        LOout,
    output logic        ZLowOut,
    output logic        ZHighOut,
    output logic        MDRout,
    output logic        Cout,
    output logic        InPortOut,
    output logic        PCout,
    output logic [4:0]  opcode,
    output logic        run,
    output logic [3:0]  step
);

    typedef enum logic [3:0] {
        S_T0    = 4'd0,
        S_T1    = 4'd1,
        S_T2    = 4'd2,
        S_T3    = 4'd3,
        S_T4    = 4'd4,
        S_T5    = 4'd5,
        S_T6    = 4'd6,
        S_T7    = 4'd7,
        S_PAUSE = 4'd8,
        S_HALT  = 4'd9
    } state_t;

    localparam logic [4:0] OP_LD   = 5'b00000;
    localparam logic [4:0] OP_LDI  = 5'b00001;
    localparam logic [4:0] OP_ST   = 5'b00010;
    localparam logic [4:0] OP_ADD  = 5'b00011;
    localparam logic [4:0] OP_AND  = 5'b00101;
    localparam logic [4:0] OP_OR   = 5'b00110;
    localparam logic [4:0] OP_ADDI = 5'b01100;
    localparam logic [4:0] OP_ANDI = 5'b01101;
    localparam logic [4:0] OP_BR   = 5'b10011;
    localparam logic [4:0] OP_JR   = 5'b10100;
    localparam logic [4:0] OP_IN   = 5'b10110;
    localparam logic [4:0] OP_OUT  = 5'b10111;
    localparam logic [4:0] OP_MFHI = 5'b11000;
    localparam logic [4:0] OP_MFLO = 5'b11001;
    localparam logic [4:0] OP_HALT = 5'b11011;

    localparam int WW = (MEM_WAIT > 0) ? $clog2(MEM_WAIT + 1) : 1;
    localparam logic [WW-1:0] WAIT_MAX = WW'(MEM_WAIT);

    state_t        state, next_state, last_state;
    logic [WW-1:0] wait_cnt;
    logic [4:0]    op;
    logic          is_rr, is_imm, is_ldx, is_muldiv, is_negnot;
    logic          mem_step;
    logic [4:0]    imm_alu;
    logic          ir_unused;

    assign op        = ir[31:27];
    assign ir_unused = ^ir[26:0];

    // Instruction classes that share an execute sequence
    assign is_rr     = (op >= 5'b00011) && (op <= 5'b01011);
    assign is_imm    = (op >= 5'b01100) && (op <= 5'b01110);
    assign is_ldx    = (op == OP_LD) || (op == OP_LDI) || (op == OP_ST);
    assign is_muldiv = (op == 5'b01111) || (op == 5'b10000);
    assign is_negnot = (op == 5'b10001) || (op == 5'b10010);

    // Immediate forms map onto the ALU operation of their register form
    assign imm_alu = (op == OP_ADDI) ? OP_ADD : (op == OP_ANDI) ? OP_AND : OP_OR;

    // Steps that wait on the RAM: the fetch read and the ld data read
    assign mem_step = (state == S_T1) || ((state == S_T6) && (op == OP_LD));

    assign step = state;
    assign run  = clr && (state <= S_T7);

    // State register and memory wait counter; the counter restarts whenever
    // the step changes so each memory step gets its full hold time
    always_ff @(posedge clk or negedge clr) begin
        if (!clr) begin
            state    <= S_T0;
            wait_cnt <= '0;
        end else begin
            state <= next_state;
            if (next_state != state) begin
                wait_cnt <= '0;
            end else if (mem_step && (wait_cnt != WAIT_MAX)) begin
                wait_cnt <= wait_cnt + 1'b1;
            end
        end
    end

    // Final execute step of the decoded instruction; illegal opcodes fall
    // into the single-step group and behave as nop
    always_comb begin
        last_state = S_T3;
        if (is_rr || is_imm || (op == OP_LDI)) begin
            last_state = S_T5;
        end else if ((op == OP_LD) || (op == OP_ST)) begin
            last_state = S_T7;
        end else if (is_muldiv || (op == OP_BR)) begin
            last_state = S_T6;
        end else if (is_negnot) begin
            last_state = S_T4;
        end
    end

    // Next-state: hold memory steps until the wait expires, then either walk
    // to the next step or, at the end of the instruction, go to HALT/PAUSE/T0
    always_comb begin
        next_state = state;
        case (state)
            S_PAUSE: if (!stop) next_state = S_T0;
            S_HALT:  next_state = S_HALT;
            default: begin
                if (mem_step && (wait_cnt != WAIT_MAX)) begin
                    next_state = state;
                end else if (state == last_state) begin
                    if ((op == OP_HALT) && (state == S_T3)) begin
                        next_state = S_HALT;
                    end else if (stop) begin
                        next_state = S_PAUSE;
                    end else begin
                        next_state = S_T0;
                    end
                end else begin
                    next_state = state_t'(state + 4'd1);
                end
            end
        endcase
    end

    // Control strobes; everything is forced low while clr is asserted so a
    // reset mid-instruction kills any pending write immediately
    always_comb begin
        read = 1'b0;  write = 1'b0;  BAout = 1'b0;  Rin = 1'b0;
        Rout = 1'b0;  Gra = 1'b0;    Grb = 1'b0;    Grc = 1'b0;
        CONN_in = 1'b0;  MARin = 1'b0;  MDRin = 1'b0;  HIin = 1'b0;
        LOin = 1'b0;  Yin = 1'b0;    Zin = 1'b0;    PCin = 1'b0;
        IRin = 1'b0;  incPC = 1'b0;  InPortIn = 1'b0;  OutPortIn = 1'b0;
        HIout = 1'b0; LOout = 1'b0;  ZLowOut = 1'b0;   ZHighOut = 1'b0;
        MDRout = 1'b0; Cout = 1'b0;  InPortOut = 1'b0; PCout = 1'b0;
        opcode = 5'b00000;
        if (clr) begin
            InPortIn = in_strobe;
            case (state)
                S_T0: begin
                    PCout = 1'b1; MARin = 1'b1; incPC = 1'b1; Zin = 1'b1;
                end
                S_T1: begin
                    ZLowOut = 1'b1; PCin = 1'b1; read = 1'b1; MDRin = 1'b1;
                end
                S_T2: begin
                    MDRout = 1'b1; IRin = 1'b1;
                end
                S_T3: begin
                    if (is_rr || is_imm || is_ldx) begin
                        Grb = 1'b1; Rout = 1'b1; Yin = 1'b1; BAout = is_ldx;
                    end else if (is_muldiv) begin
                        Gra = 1'b1; Rout = 1'b1; Yin = 1'b1;
                    end else if (is_negnot) begin
                        Grb = 1'b1; Rout = 1'b1; Zin = 1'b1; opcode = op;
                    end else if (op == OP_BR) begin
                        Gra = 1'b1; Rout = 1'b1; CONN_in = 1'b1;
                    end else if (op == OP_JR) begin
                        Gra = 1'b1; Rout = 1'b1; PCin = 1'b1;
                    end else if (op == OP_IN) begin
                        InPortOut = 1'b1; Gra = 1'b1; Rin = 1'b1;
                    end else if (op == OP_OUT) begin
                        Gra = 1'b1; Rout = 1'b1; OutPortIn = 1'b1;
                    end else if (op == OP_MFHI) begin
                        HIout = 1'b1; Gra = 1'b1; Rin = 1'b1;
                    end else if (op == OP_MFLO) begin
                        LOout = 1'b1; Gra = 1'b1; Rin = 1'b1;
                    end
                end
                S_T4: begin
                    if (is_rr) begin
                        Grc = 1'b1; Rout = 1'b1; Zin = 1'b1; opcode = op;
                    end else if (is_imm) begin
                        Cout = 1'b1; Zin = 1'b1; opcode = imm_alu;
                    end else if (is_ldx) begin
                        Cout = 1'b1; Zin = 1'b1; opcode = OP_ADD;
                    end else if (is_muldiv) begin
                        Grb = 1'b1; Rout = 1'b1; Zin = 1'b1; opcode = op;
                    end else if (is_negnot) begin
                        ZLowOut = 1'b1; Gra = 1'b1; Rin = 1'b1;
                    end else if (op == OP_BR) begin
                        PCout = 1'b1; Yin = 1'b1;
                    end
                end
                S_T5: begin
                    if (is_rr || is_imm || (op == OP_LDI)) begin
                        ZLowOut = 1'b1; Gra = 1'b1; Rin = 1'b1;
                    end else if ((op == OP_LD) || (op == OP_ST)) begin
                        ZLowOut = 1'b1; MARin = 1'b1;
                    end else if (is_muldiv) begin
                        ZLowOut = 1'b1; LOin = 1'b1;
                    end else if (op == OP_BR) begin
                        Cout = 1'b1; Zin = 1'b1; opcode = OP_ADD;
                    end
                end
                S_T6: begin
                    if (op == OP_LD) begin
                        read = 1'b1; MDRin = 1'b1;
                    end else if (op == OP_ST) begin
                        Gra = 1'b1; Rout = 1'b1; MDRin = 1'b1;
                    end else if (is_muldiv) begin
                        ZHighOut = 1'b1; HIin = 1'b1;
                    end else if ((op == OP_BR) && con_ff) begin
                        ZLowOut = 1'b1; PCin = 1'b1;
                    end
                end
                S_T7: begin
                    if (op == OP_LD) begin
                        MDRout = 1'b1; Gra = 1'b1; Rin = 1'b1;
                    end else if (op == OP_ST) begin
                        write = 1'b1;
                    end
                end
                default: begin
                end
            endcase
        end
    end

endmodule

// File: tb/tb_control_unit.sv
// -----------------------------------------------------------------------------
// tb_control_unit
//
// Drives instruction sequences into two control_unit instances (MEM_WAIT=0
// and MEM_WAIT=2) from a scoreboard queue. Each queue entry carries the
// inputs for one clock cycle plus the strobes expected during that cycle.
// -----------------------------------------------------------------------------
module tb_control_unit;

    localparam logic [27:0] C_READ      = 28'd1 << 27;
    localparam logic [27:0] C_WRITE     = 28'd1 << 26;
    localparam logic [27:0] C_BAOUT     = 28'd1 << 25;
    localparam logic [27:0] C_RIN       = 28'd1 << 24;
    localparam logic [27:0] C_ROUT      = 28'd1 << 23;
    localparam logic [27:0] C_GRA       = 28'd1 << 22;
    localparam logic [27:0] C_GRB       = 28'd1 << 21;
    localparam logic [27:0] C_GRC       = 28'd1 << 20;
    localparam logic [27:0] C_CONN_IN   = 28'd1 << 19;
    localparam logic [27:0] C_MARIN     = 28'd1 << 18;
    localparam logic [27:0] C_MDRIN     = 28'd1 << 17;
    localparam logic [27:0] C_HIIN      = 28'd1 << 16;
    localparam logic [27:0] C_LOIN      = 28'd1 << 15;
    localparam logic [27:0] C_YIN       = 28'd1 << 14;
    localparam logic [27:0] C_ZIN       = 28'd1 << 13;
    localparam logic [27:0] C_PCIN      = 28'd1 << 12;
    localparam logic [27:0] C_IRIN      = 28'd1 << 11;
    localparam logic [27:0] C_INCPC     = 28'd1 << 10;
    localparam logic [27:0] C_INPORTIN  = 28'd1 << 9;
    localparam logic [27:0] C_OUTPORTIN = 28'd1 << 8;
    localparam logic [27:0] C_HIOUT     = 28'd1 << 7;
    localparam logic [27:0] C_LOOUT     = 28'd1 << 6;
    localparam logic [27:0] C_ZLOWOUT   = 28'd1 << 5;
    localparam logic [27:0] C_ZHIGHOUT  = 28'd1 << 4;
    localparam logic [27:0] C_MDROUT    = 28'd1 << 3;
    localparam logic [27:0] C_COUT      = 28'd1 << 2;
    localparam logic [27:0] C_INPORTOUT = 28'd1 << 1;
    localparam logic [27:0] C_PCOUT     = 28'd1 << 0;

    localparam logic [27:0] F_T0 = C_PCOUT | C_MARIN | C_INCPC | C_ZIN;
    localparam logic [27:0] F_T1 = C_ZLOWOUT | C_PCIN | C_READ | C_MDRIN;
    localparam logic [27:0] F_T2 = C_MDROUT | C_IRIN;

    localparam logic [31:0] IR_ADD = 32'h18918000;
    localparam logic [31:0] IR_LD  = 32'h00900065;
    localparam logic [31:0] IR_ST  = 32'h10900065;
    localparam logic [31:0] IR_BR  = {5'b10011, 27'h0918000};
    localparam logic [31:0] IR_MUL = {5'b01111, 27'h0918000};
    localparam logic [31:0] IR_ORI = {5'b01110, 27'h0918000};
    localparam logic [31:0] IR_NEG = {5'b10001, 27'h0918000};
    localparam logic [31:0] IR_IN  = {5'b10110, 27'h0918000};
    localparam logic [31:0] IR_ILL = {5'b11111, 27'h0918000};
    localparam logic [31:0] IR_HLT = {5'b11011, 27'h0918000};

    typedef struct {
        string       tag;
        logic        clr_v;
        logic        stop_v;
        logic        con_v;
        logic        ins_v;
        logic [31:0] ir_v;
        logic [37:0] exp;
        bit          use2;
    } entry_t;

    logic        clk = 1'b0;
    logic        clr;
    logic [31:0] ir;
    logic        con_ff, stop, in_strobe;
    wire  [27:0] c1, c2;
    wire  [4:0]  opc1, opc2;
    wire         run1, run2;
    wire  [3:0]  step1, step2;
    wire  [37:0] obs1 = {c1, opc1, run1, step1};
    wire  [37:0] obs2 = {c2, opc2, run2, step2};

    entry_t sb[$];
    int     checkCount = 0;
    int     errorCount = 0;
    logic   pClr  = 1'b1;
    logic   pIns  = 1'b0;
    bit     pUse2 = 1'b0;

    always #5 clk = ~clk;

    control_unit #(.MEM_WAIT(0)) dut (
        .clk(clk), .clr(clr), .ir(ir), .con_ff(con_ff), .stop(stop),
        .in_strobe(in_strobe),
        .read(c1[27]), .write(c1[26]), .BAout(c1[25]), .Rin(c1[24]),
        .Rout(c1[23]), .Gra(c1[22]), .Grb(c1[21]), .Grc(c1[20]),
        .CONN_in(c1[19]), .MARin(c1[18]), .MDRin(c1[17]), .HIin(c1[16]),
        .LOin(c1[15]), .Yin(c1[14]), .Zin(c1[13]), .PCin(c1[12]),
        .IRin(c1[11]), .incPC(c1[10]), .InPortIn(c1[9]), .OutPortIn(c1[8]),
        .HIout(c1[7]), .LOout(c1[6]), .ZLowOut(c1[5]), .ZHighOut(c1[4]),
        .MDRout(c1[3]), .Cout(c1[2]), .InPortOut(c1[1]), .PCout(c1[0]),
        .opcode(opc1), .run(run1), .step(step1)
    );

    control_unit #(.MEM_WAIT(2)) dutWait (
        .clk(clk), .clr(clr), .ir(ir), .con_ff(con_ff), .stop(stop),
        .in_strobe(in_strobe),
        .read(c2[27]), .write(c2[26]), .BAout(c2[25]), .Rin(c2[24]),
        .Rout(c2[23]), .Gra(c2[22]), .Grb(c2[21]), .Grc(c2[20]),
        .CONN_in(c2[19]), .MARin(c2[18]), .MDRin(c2[17]), .HIin(c2[16]),
        .LOin(c2[15]), .Yin(c2[14]), .Zin(c2[13]), .PCin(c2[12]),
        .IRin(c2[11]), .incPC(c2[10]), .InPortIn(c2[9]), .OutPortIn(c2[8]),
        .HIout(c2[7]), .LOout(c2[6]), .ZLowOut(c2[5]), .ZHighOut(c2[4]),
        .MDRout(c2[3]), .Cout(c2[2]), .InPortOut(c2[1]), .PCout(c2[0]),
        .opcode(opc2), .run(run2), .step(step2)
    );

    // Single comparison point for every check in the bench
    task automatic checkOutput(input string tag, input logic [37:0] obs, input logic [37:0] exp);
        checkCount++;
        if (obs !== exp) begin
            errorCount++;
            $display("[TB] FAIL %s got ctl=%h opc=%b run=%b step=%0d expected ctl=%h opc=%b run=%b step=%0d",
                     tag, obs[37:10], obs[9:5], obs[4], obs[3:0], exp[37:10], exp[9:5], exp[4], exp[3:0]);
        end
    endtask

    // Queue one cycle: inputs to drive and the outputs expected in that cycle
    task automatic push(input string tag, input logic [31:0] irv, input logic stopv, input logic conv,
                        input logic [27:0] ctl, input logic [4:0] opc, input logic runv, input logic [3:0] stepv);
        entry_t e;
        e.tag    = tag;
        e.clr_v  = pClr;
        e.stop_v = stopv;
        e.con_v  = conv;
        e.ins_v  = pIns;
        e.ir_v   = irv;
        e.exp    = {ctl | ((pIns && pClr) ? C_INPORTIN : 28'd0), opc, runv, stepv};
        e.use2   = pUse2;
        sb.push_back(e);
    endtask

    task automatic pushFetch(input string tag, input logic [31:0] irv, input logic conv);
        push({tag, "_t0"}, irv, 1'b0, conv, F_T0, 5'd0, 1'b1, 4'd0);
        push({tag, "_t1"}, irv, 1'b0, conv, F_T1, 5'd0, 1'b1, 4'd1);
        push({tag, "_t2"}, irv, 1'b0, conv, F_T2, 5'd0, 1'b1, 4'd2);
    endtask

    task automatic pushReset(input string tag);
        pClr = 1'b0;
        push(tag, 32'd0, 1'b0, 1'b0, 28'd0, 5'd0, 1'b0, 4'd0);
        pClr = 1'b1;
    endtask

    task automatic applyStimulus(input entry_t e);
        clr       = e.clr_v;
        stop      = e.stop_v;
        con_ff    = e.con_v;
        in_strobe = e.ins_v;
        ir        = e.ir_v;
    endtask

    // Drain the scoreboard: drive on the falling edge, compare just after
    task automatic runQueue();
        entry_t e;
        while (sb.size() > 0) begin
            e = sb.pop_front();
            @(negedge clk);
            applyStimulus(e);
            #1;
            checkOutput(e.tag, e.use2 ? obs2 : obs1, e.exp);
        end
    endtask

    initial begin
        #200000;
        $display("[TB] FAIL watchdog timeout");
        $fatal(1, "[TB] simulation did not finish");
    end

    initial begin
        clr = 1'b0; ir = 32'd0; con_ff = 1'b0; stop = 1'b0; in_strobe = 1'b0;

        pushReset("rst_a");
        pushReset("rst_b");

        // ld on the MEM_WAIT=2 instance: both memory steps held three cycles
        pUse2 = 1'b1;
        push("ld_t0", IR_LD, 1'b0, 1'b0, F_T0, 5'd0, 1'b1, 4'd0);
        for (int i = 0; i < 3; i++) push("ld_t1", IR_LD, 1'b0, 1'b0, F_T1, 5'd0, 1'b1, 4'd1);
        push("ld_t2", IR_LD, 1'b0, 1'b0, F_T2, 5'd0, 1'b1, 4'd2);
        push("ld_t3", IR_LD, 1'b0, 1'b0, C_GRB | C_BAOUT | C_ROUT | C_YIN, 5'd0, 1'b1, 4'd3);
        push("ld_t4", IR_LD, 1'b0, 1'b0, C_COUT | C_ZIN, 5'b00011, 1'b1, 4'd4);
        push("ld_t5", IR_LD, 1'b0, 1'b0, C_ZLOWOUT | C_MARIN, 5'd0, 1'b1, 4'd5);
        for (int i = 0; i < 3; i++) push("ld_t6", IR_LD, 1'b0, 1'b0, C_READ | C_MDRIN, 5'd0, 1'b1, 4'd6);
        push("ld_t7", IR_LD, 1'b0, 1'b0, C_MDROUT | C_GRA | C_RIN, 5'd0, 1'b1, 4'd7);
        push("ld_next", IR_LD, 1'b0, 1'b0, F_T0, 5'd0, 1'b1, 4'd0);
        pUse2 = 1'b0;
        pushReset("rst_c");

        pushFetch("add", IR_ADD, 1'b0);
        push("add_t3", IR_ADD, 1'b0, 1'b0, C_GRB | C_ROUT | C_YIN, 5'd0, 1'b1, 4'd3);
        push("add_t4", IR_ADD, 1'b0, 1'b0, C_GRC | C_ROUT | C_ZIN, 5'b00011, 1'b1, 4'd4);
        push("add_t5", IR_ADD, 1'b0, 1'b0, C_ZLOWOUT | C_GRA | C_RIN, 5'd0, 1'b1, 4'd5);

        for (int k = 0; k < 2; k++) begin
            logic cv;
            cv = (k == 1);
            pushFetch("br", IR_BR, cv);
            push("br_t3", IR_BR, 1'b0, cv, C_GRA | C_ROUT | C_CONN_IN, 5'd0, 1'b1, 4'd3);
            push("br_t4", IR_BR, 1'b0, cv, C_PCOUT | C_YIN, 5'd0, 1'b1, 4'd4);
            push("br_t5", IR_BR, 1'b0, cv, C_COUT | C_ZIN, 5'b00011, 1'b1, 4'd5);
            push(cv ? "br_t6_taken" : "br_t6_not", IR_BR, 1'b0, cv,
                 cv ? (C_ZLOWOUT | C_PCIN) : 28'd0, 5'd0, 1'b1, 4'd6);
        end

        pushFetch("mul", IR_MUL, 1'b0);
        push("mul_t3", IR_MUL, 1'b0, 1'b0, C_GRA | C_ROUT | C_YIN, 5'd0, 1'b1, 4'd3);
        push("mul_t4", IR_MUL, 1'b0, 1'b0, C_GRB | C_ROUT | C_ZIN, 5'b01111, 1'b1, 4'd4);
        push("mul_t5", IR_MUL, 1'b0, 1'b0, C_ZLOWOUT | C_LOIN, 5'd0, 1'b1, 4'd5);
        push("mul_t6", IR_MUL, 1'b0, 1'b0, C_ZHIGHOUT | C_HIIN, 5'd0, 1'b1, 4'd6);

        pushFetch("ori", IR_ORI, 1'b0);
        push("ori_t3", IR_ORI, 1'b0, 1'b0, C_GRB | C_ROUT | C_YIN, 5'd0, 1'b1, 4'd3);
        push("ori_t4", IR_ORI, 1'b0, 1'b0, C_COUT | C_ZIN, 5'b00110, 1'b1, 4'd4);
        push("ori_t5", IR_ORI, 1'b0, 1'b0, C_ZLOWOUT | C_GRA | C_RIN, 5'd0, 1'b1, 4'd5);

        pushFetch("neg", IR_NEG, 1'b0);
        push("neg_t3", IR_NEG, 1'b0, 1'b0, C_GRB | C_ROUT | C_ZIN, 5'b10001, 1'b1, 4'd3);
        push("neg_t4", IR_NEG, 1'b0, 1'b0, C_ZLOWOUT | C_GRA | C_RIN, 5'd0, 1'b1, 4'd4);

        pIns = 1'b1;
        pushFetch("in", IR_IN, 1'b0);
        push("in_t3", IR_IN, 1'b0, 1'b0, C_INPORTOUT | C_GRA | C_RIN, 5'd0, 1'b1, 4'd3);
        pIns = 1'b0;

        pushFetch("ill", IR_ILL, 1'b0);
        push("ill_t3", IR_ILL, 1'b0, 1'b0, 28'd0, 5'd0, 1'b1, 4'd3);

        // st with stop raised at T5: store completes, then PAUSE
        pushFetch("st", IR_ST, 1'b0);
        push("st_t3", IR_ST, 1'b0, 1'b0, C_GRB | C_BAOUT | C_ROUT | C_YIN, 5'd0, 1'b1, 4'd3);
        push("st_t4", IR_ST, 1'b0, 1'b0, C_COUT | C_ZIN, 5'b00011, 1'b1, 4'd4);
        push("st_t5", IR_ST, 1'b1, 1'b0, C_ZLOWOUT | C_MARIN, 5'd0, 1'b1, 4'd5);
        push("st_t6", IR_ST, 1'b1, 1'b0, C_GRA | C_ROUT | C_MDRIN, 5'd0, 1'b1, 4'd6);
        push("st_t7", IR_ST, 1'b1, 1'b0, C_WRITE, 5'd0, 1'b1, 4'd7);
        push("pause_a", IR_ST, 1'b1, 1'b0, 28'd0, 5'd0, 1'b0, 4'd8);
        push("pause_b", IR_ST, 1'b0, 1'b0, 28'd0, 5'd0, 1'b0, 4'd8);

        // Second st aborted by reset during T6
        pushFetch("sta", IR_ST, 1'b0);
        push("sta_t3", IR_ST, 1'b0, 1'b0, C_GRB | C_BAOUT | C_ROUT | C_YIN, 5'd0, 1'b1, 4'd3);
        push("sta_t4", IR_ST, 1'b0, 1'b0, C_COUT | C_ZIN, 5'b00011, 1'b1, 4'd4);
        push("sta_t5", IR_ST, 1'b0, 1'b0, C_ZLOWOUT | C_MARIN, 5'd0, 1'b1, 4'd5);
        push("sta_t6", IR_ST, 1'b0, 1'b0, C_GRA | C_ROUT | C_MDRIN, 5'd0, 1'b1, 4'd6);
        pushReset("sta_abort");
        pushReset("sta_abort_hold");

        pushFetch("hlt", IR_HLT, 1'b0);
        push("hlt_t3", IR_HLT, 1'b0, 1'b0, 28'd0, 5'd0, 1'b1, 4'd3);
        for (int i = 0; i < 20; i++) push("halted", IR_HLT, 1'b0, 1'b0, 28'd0, 5'd0, 1'b0, 4'd9);
        pushReset("hlt_clr");
        push("restart_t0", IR_ADD, 1'b0, 1'b0, F_T0, 5'd0, 1'b1, 4'd0);
        push("restart_t1", IR_ADD, 1'b0, 1'b0, F_T1, 5'd0, 1'b1, 4'd1);

        runQueue();

        $display("CHECKS %0d ERRORS %0d", checkCount, errorCount);
        $finish;
    end

endmodule
